// File: rtl/systolic_fpga_example_counter_bank.sv
// Bank of independent up/down counters with per-channel load and variable step.
// Each channel can either wrap modulo 2^C_WIDTH or saturate at 0 / all-ones.
// It also produces registered zero, terminal-count and one-cycle overflow flags.
// All outputs come straight from flops and update one cycle after the inputs.
module systolic_fpga_example_counter_bank #(
   parameter int                 C_CHANNELS   = 32'd4,
   parameter int                 C_WIDTH      = 32'd16,
   parameter int                 C_STEP_WIDTH = 32'd4,
   parameter int                 C_SATURATE   = 32'd0,
   parameter logic [C_WIDTH-1:0] C_INIT       = {C_WIDTH{1'b0}}
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             clken,
   input  logic [C_CHANNELS-1:0]            load,
   input  logic [C_CHANNELS-1:0]            incr,
   input  logic [C_CHANNELS-1:0]            decr,
   input  logic [C_CHANNELS*C_STEP_WIDTH-1:0] step,
   input  logic [C_CHANNELS*C_WIDTH-1:0]    load_value,
   input  logic [C_WIDTH-1:0]               term_value,
   output logic [C_CHANNELS*C_WIDTH-1:0]    count,
   output logic [C_CHANNELS-1:0]            is_zero,
   output logic [C_CHANNELS-1:0]            at_term,
   output logic [C_CHANNELS-1:0]            ovf
);

   localparam logic [C_WIDTH-1:0] ALL_ONES = {C_WIDTH{1'b1}};
   localparam logic [C_WIDTH-1:0] ALL_ZERO = {C_WIDTH{1'b0}};
   localparam logic [C_STEP_WIDTH-1:0] STEP_ZERO = {C_STEP_WIDTH{1'b0}};

   for (genvar i = 0; i < C_CHANNELS; i++) begin : g_ch
      logic [C_WIDTH-1:0]      count_d, count_q;
      logic                    is_zero_d, is_zero_q;
      logic                    at_term_d, at_term_q;
      logic                    ovf_d, ovf_q;
      logic [C_STEP_WIDTH-1:0] step_s;
      logic [C_WIDTH:0]        cur_x_s, step_x_s, sum_s, diff_s;
      logic                    step_nz_s, go_up_s, go_down_s;

      // Arithmetic is one bit wider than the counter so bit C_WIDTH is the carry/borrow.
      assign step_s    = step[i*C_STEP_WIDTH +: C_STEP_WIDTH];
      assign cur_x_s   = {1'b0, count_q};
      assign step_x_s  = {{(C_WIDTH+1-C_STEP_WIDTH){1'b0}}, step_s};
      assign sum_s     = cur_x_s + step_x_s;
      assign diff_s    = cur_x_s - step_x_s;
      assign step_nz_s = (step_s != STEP_ZERO);
      assign go_up_s   = incr[i] & ~decr[i] & step_nz_s;
      assign go_down_s = decr[i] & ~incr[i] & step_nz_s;

      // Next-count selection: load beats a step update, everything else holds.
      always_comb begin
         count_d = count_q;
         ovf_d   = 1'b0;
         if (load[i]) begin
            count_d = load_value[i*C_WIDTH +: C_WIDTH];
            ovf_d   = 1'b0;
         end else if (go_up_s) begin
            if (sum_s[C_WIDTH]) begin
               ovf_d = 1'b1;
               if (C_SATURATE != 32'd0) begin
                  count_d = ALL_ONES;
               end else begin
                  count_d = sum_s[C_WIDTH-1:0];
               end
            end else begin
               count_d = sum_s[C_WIDTH-1:0];
               ovf_d   = 1'b0;
            end
         end else if (go_down_s) begin
            if (diff_s[C_WIDTH]) begin
               ovf_d = 1'b1;
               if (C_SATURATE != 32'd0) begin
                  count_d = ALL_ZERO;
               end else begin
                  count_d = diff_s[C_WIDTH-1:0];
               end
            end else begin
               count_d = diff_s[C_WIDTH-1:0];
               ovf_d   = 1'b0;
            end
         end else begin
            count_d = count_q;
            ovf_d   = 1'b0;
         end
         // Flags follow the value about to be registered so they never lag the count.
         is_zero_d = (count_d == ALL_ZERO);
         at_term_d = (count_d == term_value);
      end

      // State register: reset beats the enable; a disabled edge only clears the ovf pulse.
      always_ff @(posedge clk) begin
         if (rst) begin
            count_q   <= C_INIT;
            is_zero_q <= (C_INIT == ALL_ZERO);
            at_term_q <= 1'b0;
            ovf_q     <= 1'b0;
         end else if (clken) begin
            count_q   <= count_d;
            is_zero_q <= is_zero_d;
            at_term_q <= at_term_d;
            ovf_q     <= ovf_d;
         end else begin
            ovf_q     <= 1'b0;
         end
      end

      assign count[i*C_WIDTH +: C_WIDTH] = count_q;
      assign is_zero[i]                  = is_zero_q;
      assign at_term[i]                  = at_term_q;
      assign ovf[i]                      = ovf_q;
   end

endmodule
